// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the default geometry (32-bit words, 256-bit vectors, 1024-word RAM),
// the constants derived from it, and the burst state encoding.
package dmem_pkg;

  localparam int DMEM_N     = 32;
  localparam int DMEM_V     = 256;
  localparam int DMEM_DEPTH = 1024;

  localparam int BEATS           = DMEM_V / DMEM_N;     // words per vector
  localparam int BYTES_PER_WORD  = DMEM_N / 8;
  localparam int CNT_W           = $clog2(BEATS);
  // Low address bits that must be zero for a word / a vector access
  localparam int WORD_ALIGN_BITS = $clog2(BYTES_PER_WORD);
  localparam int VEC_ALIGN_BITS  = $clog2(DMEM_V / 8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VREAD  = 2'd1,
    VWRITE = 2'd2,
    VDONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bytewise_ram.sv
// DEPTH x N synchronous RAM with one write port (per-byte enables) and one
// read port with a registered output (data appears one edge after re).
// The array and the read register are not reset.
//   clk   : rising-edge clock
//   we    : byte-lane write enables, bit b covers wdata[8b+7:8b]
//   waddr : write word address
//   wdata : write data
//   re    : read enable; rdata holds when low
//   raddr : read word address
//   rdata : registered read data
module bytewise_ram #(
  parameter int N     = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic [N/8-1:0] we,
  input  logic [AW-1:0]  waddr,
  input  logic [N-1:0]   wdata,
  input  logic           re,
  input  logic [AW-1:0]  raddr,
  output logic [N-1:0]   rdata
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < N/8; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the processor data-memory port. Serves scalar word
// reads/writes (byte-enabled) with one-cycle read latency, and 256-bit
// vector loads/stores as 8-beat word bursts during which Busy stalls the
// pipeline. Misaligned or out-of-range requests are dropped and flagged.
//   clk, rst    : clock, asynchronous active-high reset
//   AddressData : byte address; ByteenaData: scalar write lane enables
//   WriteData   : scalar write data; WriteDataV: vector write data
//   RdenData / WrenData : read / write request (write wins if both)
//   VecReq      : request is a vector access
//   ReadData / ReadDataV : scalar / assembled vector read data (held)
//   ReadValid   : one-cycle pulse marking fresh read data
//   Busy        : vector burst in progress
//   AddrError   : one-cycle pulse, request rejected
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int N     = DMEM_N,
  parameter int V     = DMEM_V,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              AddressData,
  input  logic [BYTES_PER_WORD-1:0] ByteenaData,
  input  logic [N-1:0]              WriteData,
  input  logic [V-1:0]              WriteDataV,
  input  logic                      RdenData,
  input  logic                      WrenData,
  input  logic                      VecReq,
  output logic [N-1:0]              ReadData,
  output logic [V-1:0]              ReadDataV,
  output logic                      ReadValid,
  output logic                      Busy,
  output logic                      AddrError
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [N:0]       DEPTH_X = (N+1)'(DEPTH);
  localparam logic [N:0]       BEATS_X = (N+1)'(BEATS);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(BEATS-1);

  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    base;
  logic [V-1:0]     wv;
  logic             sc_rd;
  logic [N-1:0]     rd_hold, ram_rdata;

  logic [N-WORD_ALIGN_BITS-1:0] widx;
  logic [N:0]                   widx_x;
  logic scal_ok, vec_ok, req, last;
  logic acc_sw, acc_sr, acc_vr, acc_vw, rej;

  logic [BYTES_PER_WORD-1:0] ram_we;
  logic [AW-1:0]             ram_waddr, ram_raddr;
  logic [N-1:0]              ram_wdata;
  logic                      ram_re;

  // Range checks are done one bit wider so base+BEATS cannot wrap
  assign widx    = AddressData[N-1:WORD_ALIGN_BITS];
  assign widx_x  = (N+1)'(widx);
  assign scal_ok = (AddressData[WORD_ALIGN_BITS-1:0] == '0) && (widx_x < DEPTH_X);
  assign vec_ok  = (AddressData[VEC_ALIGN_BITS-1:0] == '0) && (widx_x + BEATS_X <= DEPTH_X);
  assign req     = RdenData | WrenData;
  assign last    = (cnt == LAST);
  assign Busy    = (state == VREAD) || (state == VWRITE);

  // The RAM output register is only trusted in the cycle after a scalar
  // read; otherwise the held copy is shown, so vector beats streaming
  // through the RAM never disturb ReadData.
  assign ReadData = sc_rd ? ram_rdata : rd_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    acc_sw  = 1'b0;
    acc_sr  = 1'b0;
    acc_vr  = 1'b0;
    acc_vw  = 1'b0;
    rej     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (VecReq) begin
            if (!vec_ok)       rej = 1'b1;
            else if (WrenData) begin acc_vw = 1'b1; state_n = VWRITE; end
            else               begin acc_vr = 1'b1; state_n = VREAD;  end
          end else begin
            if (!scal_ok)      rej    = 1'b1;
            else if (WrenData) acc_sw = 1'b1;
            else               acc_sr = 1'b1;
          end
        end
      end
      VREAD, VWRITE: if (last) state_n = VDONE;
      VDONE:         state_n = IDLE;
      default:       state_n = IDLE;
    endcase
  end

  // RAM port steering. A vector read issues word 0 on the accept edge and
  // word k+1 while lane k is captured, so the last beat issues no read.
  always_comb begin
    ram_we    = '0;
    ram_waddr = widx[AW-1:0];
    ram_wdata = WriteData;
    ram_re    = 1'b0;
    ram_raddr = widx[AW-1:0];
    if (acc_sw)          ram_we = ByteenaData;
    if (acc_sr || acc_vr) ram_re = 1'b1;
    if (state == VREAD) begin
      ram_re    = !last;
      ram_raddr = base + AW'(cnt) + AW'(1);
    end
    if (state == VWRITE) begin
      ram_we    = '1;
      ram_waddr = base + AW'(cnt);
      ram_wdata = wv[cnt*N +: N];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      base      <= '0;
      wv        <= '0;
      ReadDataV <= '0;
      ReadValid <= 1'b0;
      AddrError <= 1'b0;
      sc_rd     <= 1'b0;
      rd_hold   <= '0;
    end else begin
      AddrError <= rej;
      ReadValid <= acc_sr | ((state == VREAD) && last);
      sc_rd     <= acc_sr;
      rd_hold   <= ReadData;
      if (acc_vr || acc_vw) begin
        base <= widx[AW-1:0];
        cnt  <= '0;
      end
      if (acc_vw) wv <= WriteDataV;
      if (Busy) begin
        cnt <= last ? '0 : cnt + CNT_W'(1);
        if (state == VREAD) ReadDataV[cnt*N +: N] <= ram_rdata;
      end
    end
  end

  bytewise_ram #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  AddressData;
  logic [3:0]   ByteenaData;
  logic [31:0]  WriteData;
  logic [255:0] WriteDataV;
  logic         RdenData, WrenData, VecReq;
  logic [31:0]  ReadData;
  logic [255:0] ReadDataV;
  logic         ReadValid, Busy, AddrError;

  int checks = 0;
  int errors = 0;

  // reference model: word array plus expected held outputs
  logic [31:0]  mem_m [DEPTH];
  logic [31:0]  exp_rd  = '0;
  logic [255:0] exp_rdv = '0;

  always #5 clk = ~clk;

  data_mem_responder #(.N(32), .V(256), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .AddressData(AddressData), .ByteenaData(ByteenaData),
    .WriteData(WriteData), .WriteDataV(WriteDataV), .RdenData(RdenData),
    .WrenData(WrenData), .VecReq(VecReq), .ReadData(ReadData), .ReadDataV(ReadDataV),
    .ReadValid(ReadValid), .Busy(Busy), .AddrError(AddrError)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ok_scalar(input logic [31:0] a);
    return (a % 4 == 0) && ((a / 4) < DEPTH);
  endfunction

  function automatic bit ok_vec(input logic [31:0] a);
    return (a % 32 == 0) && ((a / 4) + 8 <= DEPTH);
  endfunction

  task automatic set_idle();
    AddressData = '0; ByteenaData = '0; WriteData = '0; WriteDataV = '0;
    RdenData = 1'b0; WrenData = 1'b0; VecReq = 1'b0;
  endtask

  task automatic scalar_op(input logic [31:0] a, input logic rd, input logic wr,
                           input logic [3:0] be, input logic [31:0] d);
    int idx;
    idx = int'(a / 4);
    @(negedge clk);
    AddressData = a; RdenData = rd; WrenData = wr; VecReq = 1'b0;
    ByteenaData = be; WriteData = d;
    @(posedge clk); #1;
    set_idle();
    if (!ok_scalar(a)) begin
      chk("s_err", AddrError, 1);
      chk("s_err_nv", ReadValid, 0);
    end else begin
      chk("s_noerr", AddrError, 0);
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
        chk("s_wr_nv", ReadValid, 0);
      end else begin
        exp_rd = mem_m[idx];
        chk("s_rd_valid", ReadValid, 1);
      end
    end
    chk("s_rdata", ReadData, exp_rd);
    chk("s_busy", Busy, 0);
    @(posedge clk); #1;
    chk("s_rv_pulse", ReadValid, 0);
    chk("s_err_pulse", AddrError, 0);
    chk("s_rd_hold", ReadData, exp_rd);
  endtask

  // hold=1 keeps a misaligned scalar read asserted from the accept edge on;
  // it must only be taken once the burst has fully returned to idle.
  task automatic vec_op(input logic [31:0] a, input logic wr, input logic [255:0] v,
                        input bit hold);
    int idx, busy_n;
    idx = int'(a / 4);
    @(negedge clk);
    AddressData = a; VecReq = 1'b1; RdenData = !wr; WrenData = wr;
    WriteDataV = v; ByteenaData = 4'($urandom);
    @(posedge clk); #1;
    if (hold) begin
      AddressData = 32'h13; RdenData = 1'b1; WrenData = 1'b0; VecReq = 1'b0;
    end else set_idle();
    if (!ok_vec(a)) begin
      chk("v_err", AddrError, 1);
      chk("v_err_busy", Busy, 0);
      chk("v_err_nv", ReadValid, 0);
      @(posedge clk); #1;
      chk("v_err_pulse", AddrError, 0);
      chk("v_err_busy2", Busy, 0);
      return;
    end
    chk("v_noerr", AddrError, 0);
    busy_n = 0;
    for (int i = 0; i < 12 && Busy; i++) begin
      if (hold) chk("hold_ignored", AddrError, 0);
      busy_n++;
      @(posedge clk); #1;
    end
    chk("v_busy_len", busy_n, 8);
    if (wr) begin
      for (int k = 0; k < 8; k++) mem_m[idx+k] = v[32*k +: 32];
      chk("vw_done_nv", ReadValid, 0);
    end else begin
      for (int k = 0; k < 8; k++) exp_rdv[32*k +: 32] = mem_m[idx+k];
      chk("vr_valid", ReadValid, 1);
    end
    chk("v_rdatav", ReadDataV, exp_rdv);
    chk("v_rd_hold", ReadData, exp_rd);
    if (hold) chk("hold_vdone", AddrError, 0);
    @(posedge clk); #1;
    chk("v_done_nv", ReadValid, 0);
    chk("v_done_busy", Busy, 0);
    if (hold) begin
      chk("hold_idle", AddrError, 0);
      @(posedge clk); #1;
      set_idle();
      chk("hold_taken", AddrError, 1);
      chk("hold_taken_nv", ReadValid, 0);
      @(posedge clk); #1;
      chk("hold_pulse", AddrError, 0);
    end
  endtask

  initial begin
    logic [255:0] v;
    logic [31:0]  a;
    int           op;

    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", ReadData, 0);
    chk("rst_rdatav", ReadDataV, 0);
    chk("rst_rvalid", ReadValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_err", AddrError, 0);
    @(negedge clk) rst = 1'b0;

    // known contents for words 0..127
    for (int i = 0; i < 128; i++) scalar_op(32'(i*4), 1'b0, 1'b1, 4'hF, $urandom);

    // basic scalar write/read and byte-lane merge
    scalar_op(32'h10, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF);
    scalar_op(32'h10, 1'b1, 1'b0, 4'h0, 32'h0);
    chk("t1_const", ReadData, 32'hDEADBEEF);
    scalar_op(32'h10, 1'b0, 1'b1, 4'h5, 32'h11223344);
    scalar_op(32'h10, 1'b1, 1'b0, 4'h0, 32'h0);
    chk("t2_const", ReadData, 32'hDE22BE44);
    scalar_op(32'h10, 1'b0, 1'b1, 4'h0, 32'hFFFFFFFF);  // byteena 0 is a no-op
    scalar_op(32'h10, 1'b1, 1'b0, 4'h0, 32'h0);

    // vector write / read and lane mapping
    for (int k = 0; k < 8; k++) v[32*k +: 32] = 32'hA0000000 + 32'(k);
    vec_op(32'h40, 1'b1, v, 1'b0);
    vec_op(32'h40, 1'b0, '0, 1'b0);
    chk("t3_vec_const", ReadDataV, v);
    scalar_op(32'h4C, 1'b1, 1'b0, 4'h0, 32'h0);
    chk("t3_lane3", ReadData, 32'hA0000003);

    // rejects and range boundaries
    scalar_op(32'h13, 1'b1, 1'b0, 4'h0, 32'h0);
    scalar_op(32'(DEPTH*4), 1'b1, 1'b0, 4'h0, 32'h0);
    vec_op(32'h44, 1'b0, '0, 1'b0);
    scalar_op(32'(DEPTH*4 - 4), 1'b0, 1'b1, 4'hF, 32'hCAFEF00D);
    scalar_op(32'(DEPTH*4 - 4), 1'b1, 1'b0, 4'h0, 32'h0);
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    vec_op(32'(DEPTH*4 - 32), 1'b1, v, 1'b0);
    vec_op(32'(DEPTH*4 - 32), 1'b0, '0, 1'b0);
    vec_op(32'(DEPTH*4), 1'b0, '0, 1'b0);
    scalar_op(32'h20, 1'b1, 1'b0, 4'h0, 32'h0);  // rejects above left ReadData alone

    // reset in the middle of a vector write at 0x80
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    @(negedge clk);
    AddressData = 32'h80; VecReq = 1'b1; WrenData = 1'b1; WriteDataV = v;
    @(posedge clk); #1;
    set_idle();
    chk("t5_busy", Busy, 1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", Busy, 0);
    chk("t5_rst_rv", ReadValid, 0);
    chk("t5_rst_err", AddrError, 0);
    chk("t5_rst_rdata", ReadData, 0);
    chk("t5_rst_rdatav", ReadDataV, 0);
    for (int k = 0; k < 4; k++) mem_m[32+k] = v[32*k +: 32];
    exp_rd = '0; exp_rdv = '0;
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 8; k++) scalar_op(32'h80 + 32'(4*k), 1'b1, 1'b0, 4'h0, 32'h0);

    // read+write together: write wins; request held through a burst
    scalar_op(32'h20, 1'b1, 1'b1, 4'hF, 32'h5);
    scalar_op(32'h20, 1'b1, 1'b0, 4'h0, 32'h0);
    chk("t6_const", ReadData, 32'h5);
    vec_op(32'h40, 1'b0, '0, 1'b1);

    // randomized traffic over words 0..127
    for (int n = 0; n < 300; n++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 5) begin
        a = 32'($urandom_range(0, 127)) * 4;
        if ($urandom_range(0, 9) == 0)
          a = $urandom_range(0, 1) ? a + 32'($urandom_range(1, 3)) : a + 32'(DEPTH*4);
        case (op)
          0, 1, 2: scalar_op(a, 1'b0, 1'b1, 4'($urandom), $urandom);
          3, 4:    scalar_op(a, 1'b1, 1'b0, 4'h0, 32'h0);
          default: scalar_op(a, 1'b1, 1'b1, 4'($urandom), $urandom);
        endcase
      end else begin
        a = 32'($urandom_range(0, 15)) * 32;
        if ($urandom_range(0, 7) == 0)
          a = $urandom_range(0, 1) ? a + 32'($urandom_range(1, 7) * 4) : a + 32'(DEPTH*4);
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
        vec_op(a, (op <= 7), v, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
